// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types for the instruction fetch unit
package fetch_unit_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t addr;
    word_t data;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_e;
endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular prefetch FIFO of {addr, data} entries
//   clk/_reset (async, active-low); push+wdata append, pop drops head, flush empties;
//   head, count, full, empty report occupancy (wrap bit separates full from empty).
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   _reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push && !flush);
      rp <= flush ? wp : rp + (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prefetching instruction responder between core fetch port and instruction memory
//   clk, _reset (async, active-low); core side: pointer, fetch_req -> instr_out, instr_valid;
//   memory side: mem_req, mem_addr -> mem_ack, mem_rdata (one request outstanding at a time).
//   FETCH_BYPASS_EN: forward mem_rdata straight to the core when the acked word is the one it wants.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int    DEPTH      = 4,
  parameter word_t RESET_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic [31:0] pointer,
  input  logic        fetch_req,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  fetch_state_e state, state_nx;
  word_t next_addr, stale_addr;
  fetch_entry_t head, entry;
  logic [AW:0] count, count_nx;
  logic full, empty, hit, redirect, ack_ok, bypass, push;
  assign entry = '{addr: next_addr, data: mem_rdata};
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk, ._reset, .push, .pop(hit), .flush(redirect), .wdata(entry),
    .head, .count, .full, .empty
  );
  assign hit = fetch_req && !empty && head.addr == pointer;
  // a mismatching head flushes the queue; an empty queue only needs a new fetch address
  assign redirect = fetch_req && (empty ? pointer != next_addr : head.addr != pointer);
  assign ack_ok = state == REQ && mem_ack && !redirect;
`ifdef FETCH_BYPASS_EN
  assign bypass = ack_ok && empty && fetch_req;
`else
  assign bypass = 1'b0;
`endif
  assign push = ack_ok && !bypass && !full;
  assign count_nx = redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(hit);
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) state <= IDLE;
    else state <= state_nx;
  // count never exceeds DEPTH, so its top bit set means the queue leaves no credit
  always_comb begin
    state_nx = state;
    if (state == DISCARD) state_nx = mem_ack ? IDLE : DISCARD;
    else if (state == REQ && redirect) state_nx = mem_ack ? IDLE : DISCARD;
    else if (state == IDLE || mem_ack) state_nx = count_nx[AW] ? IDLE : REQ;
  end
  always_comb begin
    mem_req = state != IDLE;
    mem_addr = state == DISCARD ? stale_addr : next_addr;
    instr_valid = hit || bypass;
    instr_out = hit ? head.data : bypass ? mem_rdata : '0;
  end
  // stale_addr shadows next_addr so the in-flight address survives a redirect
  always_ff @(posedge clk or negedge _reset)
    if (!_reset) begin
      next_addr <= RESET_ADDR;
      stale_addr <= RESET_ADDR;
    end else begin
      next_addr <= redirect ? pointer : next_addr + 32'(ack_ok);
      stale_addr <= state == DISCARD ? stale_addr : next_addr;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RA = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0, _reset = 1'b0, fetch_req = 1'b0, mem_ack = 1'b0;
  logic [31:0] pointer = '0, mem_rdata = '0;
  logic instr_valid, mem_req;
  logic [31:0] instr_out, mem_addr;

  fetch_unit #(.DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clk(clk), ._reset(_reset), .pointer(pointer), .fetch_req(fetch_req),
    .instr_out(instr_out), .instr_valid(instr_valid), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  logic [31:0] na, sa;
  bit busy, stale;
  int checks = 0, errors = 0, cyc = 0, dly_cnt = 2, fixed_dly = 2, last_ack_cyc = -1;
  logic [31:0] ack_log[$];
  bit ev, got_v, got_r;
  logic [31:0] got_o, got_a;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    na = RA;
    sa = RA;
    busy = 0;
    stale = 0;
  endtask

  // transaction view: busy = a read is outstanding, stale = its data will be thrown away
  task automatic model_step(bit fr, logic [31:0] p, bit ack, logic [31:0] rd);
    bit hit, redir, byp;
    hit = fr && q.size() > 0 && q[0].a == p;
    redir = fr && !hit && (q.size() > 0 || p != na);
    byp = BYP && fr && q.size() == 0 && busy && !stale && ack && p == na;
    if (redir) begin
      q.delete();
      if (busy && !stale) begin
        if (ack) busy = 0;
        else begin
          stale = 1;
          sa = na;
        end
      end else if (busy) begin
        if (ack) begin
          busy = 0;
          stale = 0;
        end
      end else busy = 1;
      na = p;
    end else begin
      if (hit) void'(q.pop_front());
      if (busy && stale) begin
        if (ack) begin
          busy = 0;
          stale = 0;
        end
      end else if (busy) begin
        if (ack) begin
          if (!byp) q.push_back('{na, rd});
          na = na + 1;
          busy = q.size() < DEPTH;
        end
      end else busy = q.size() < DEPTH;
    end
  endtask

  task automatic drive_mem();
    if (mem_req) begin
      if (dly_cnt == 0) begin
        mem_ack = 1'b1;
        mem_rdata = memf(mem_addr);
        ack_log.push_back(mem_addr);
        last_ack_cyc = cyc;
        dly_cnt = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
      end else begin
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        dly_cnt--;
      end
    end else begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic tick(bit fr, logic [31:0] p);
    logic [31:0] eo;
    cyc++;
    fetch_req = fr;
    pointer = p;
    drive_mem();
    #1;
    ev = 0;
    eo = '0;
    if (fr && q.size() > 0 && q[0].a == p) begin
      ev = 1;
      eo = q[0].d;
    end else if (BYP && fr && q.size() == 0 && busy && !stale && mem_ack && p == na) begin
      ev = 1;
      eo = mem_rdata;
    end
    got_v = instr_valid;
    got_o = instr_out;
    got_r = mem_req;
    got_a = mem_addr;
    check("instr_valid", got_v, ev);
    if (ev || q.size() == 0) check("instr_out", got_o, eo);
    check("mem_req", got_r, busy);
    check("mem_addr", got_a, stale ? sa : na);
    @(posedge clk);
    model_step(fr, p, mem_ack, mem_rdata);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    _reset = 1'b0;
    fetch_req = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_addr", mem_addr, RA);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    _reset = 1'b1;
    dly_cnt = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int n, hold, nv;
    logic [31:0] st, pc;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_out", instr_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, RA);
    @(negedge clk);
    _reset = 1'b1;
    repeat (20) tick(1'b0, 32'h0);
    check("p1_nreq", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) check("p1_req_addr", ack_log.size() > i ? ack_log[i] : 32'hFFFF_FFFF, i);
    check("p1_idle", got_r, 0);
    check("p1_model_fill", q.size(), 4);
    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 32'(i));
      check("p2_valid", got_v, 1);
      check("p2_data", got_o, memf(32'(i)));
    end
    repeat (20) tick(1'b0, 32'h4);
    check("p2_refill", ack_log.size() > 0 ? ack_log[0] : 32'hFFFF_FFFF, 4);
    tick(1'b1, 32'd20);
    check("p3_miss_valid", got_v, 0);
    n = 0;
    do begin
      tick(1'b1, 32'd20);
      n++;
    end while (n < 20 && !got_v);
    check("p3_valid", got_v, 1);
    check("p3_data", got_o, memf(32'd20));
    check("p3_latency", cyc - last_ack_cyc, BYP ? 0 : 1);
    fixed_dly = 3;
    n = 0;
    while (n < 40 && !(mem_req && dly_cnt == fixed_dly && busy && !stale)) begin
      tick(1'b0, 32'd21);
      n++;
    end
    check("p4_found", n < 40, 1);
    st = mem_addr;
    tick(1'b1, 32'd40);
    hold = 0;
    nv = int'(got_v);
    n = 0;
    do begin
      tick(1'b1, 32'd40);
      nv += int'(got_v);
      if (got_a == st) hold++;
      n++;
    end while (n < 10 && got_a == st);
    check("p4_hold", hold, 3);
    check("p4_no_stale_data", nv, 0);
    check("p4_new_addr", got_a, 40);
    fixed_dly = 2;
    n = 0;
    while (n < 40 && !(mem_req && dly_cnt == 0 && busy && !stale)) begin
      tick(1'b0, 32'd41);
      n++;
    end
    check("p5_found", n < 40, 1);
    st = mem_addr;
    tick(1'b1, 32'd100);
    check("p5_valid", got_v, 0);
    check("p5_acked", ack_log.size() > 0 ? ack_log[$] : 32'hFFFF_FFFF, st);
    tick(1'b1, 32'd100);
    check("p5_req", got_r, 0);
    check("p5_addr", got_a, 100);
    n = 0;
    do begin
      tick(1'b1, 32'd100);
      n++;
    end while (n < 20 && !got_v);
    check("p5_data", got_o, memf(32'd100));
    n = 0;
    while (n < 20 && !mem_req) begin
      tick(1'b0, 32'd101);
      n++;
    end
    check("p6_req_before", mem_req, 1);
    do_reset();
    tick(1'b0, 32'd7);
    check("p6_req_after", got_r, 0);
    check("p6_addr_after", got_a, RA);
    tick(1'b0, 32'd7);
    check("p6_first_req", got_r, 1);
    check("p6_first_addr", got_a, RA);
    fixed_dly = -1;
    pc = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) do_reset();
      if (r < 60) pc = 32'($urandom_range(0, 63));
      else if (r < 70) pc = 32'hFFFF_FFFD;
      else if (r < 90) pc = $urandom;
      tick($urandom_range(0, 9) < 8, pc);
      if (ev) pc = pc + 1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
